piezo_sfx: RTL and testbench
============================

# piezo_sfx

Sound-effect sequencer for the FORTRESS game, downstream of the tank game logic. It watches both tank life counters and the fire strobe. Each qualifying event plays a short square-wave jingle on the piezo output: hit, win, or an optional fire blip. Runs on the system clock and replaces the fixed-tone piezo driver at the top level.

## Interface
- `CLK_HZ`, 1000000, frequency of `clk` in Hz.
- `NOTE_MS`, 125, duration of every note/rest in ms.
  - NOTE_CYC = (CLK_HZ/1000)*NOTE_MS clock cycles.

- `clk`  in  1  system clock.
- `nrst`  in  1  synchronous reset, active-high, sampled on rising `clk`.
- `tank1_life`  in  2  tank 1 remaining lives, 0..3.
- `tank2_life`  in  2  tank 2 remaining lives, 0..3.
- `fire`  in  1  level from tank logic; rising edge = shot fired.
- `piezo_out`  out  1  square-wave drive to piezo.
- `busy`  out  1  high while a sequence plays.
- `game_over`  out  1  sticky; set when any life reaches 0.

## Operation
- **Tone table.** Half-period counts are HALF(f) = CLK_HZ/(2*f), integer floor:
  - C5 = 523 Hz
  - E5 = 659 Hz
  - G5 = 784 Hz
  - C6 = 1047 Hz
  - REST = output held 0.
- **Sequences** (each note lasts NOTE_CYC):
  - HIT = G5, E5, C5.
  - WIN = C5, E5, G5, C6, REST, C6.
  - FIRE = C6 (only when the macro is enabled).
- **Event detection.** Previous lives (`p1`, `p2`) are registered every cycle.
  - The first cycle after reset only loads `p1`/`p2`; no events are raised on that cycle.
  - WIN event: a life is 0 while its previous value was nonzero.
  - HIT event: a life is below its previous value but not 0.
  - FIRE event: `fire` is 1 while its previous value was 0.
  - Life increases are ignored.
- **Priority:** WIN > HIT > FIRE. Simultaneous events on both tanks produce a single sequence of the highest class.
- **FSM states:** IDLE, PLAY, OVER.
  - IDLE → PLAY on any event. Load the sequence, note index 0, clear counters.
  - PLAY, when a note's NOTE_CYC expires:
    - not the last note → advance the index;
    - last note of HIT/FIRE → IDLE;
    - last note of WIN → OVER.
  - PLAY with a new event of strictly higher class → restart in that sequence. Equal or lower class events are dropped.
  - OVER: all events ignored; exits only by reset.
- **Tone generation.**
  - The half-period counter counts 0..HALF-1, then toggles `piezo_out` and wraps to 0.
  - At every note start the counter clears and `piezo_out` is forced to 0.
  - On REST, `piezo_out` stays 0.
- **Outputs per state.**
  - `busy` = 1 exactly in PLAY.
  - `game_over` = 1 from the first cycle of the WIN sequence onward, and stays 1 through OVER.
  - `piezo_out` = 0 in IDLE and OVER.
- **Reset values:** `piezo_out`=0, `busy`=0, `game_over`=0, state=IDLE, all counters 0.
- **Reset mid-sequence** aborts immediately. No event is generated from the life values present after reset.

## Timing
- **Event latency.** An event sampled at edge N gives `busy`=1 after edge N+1.
- **First edge.** The first `piezo_out` toggle comes HALF cycles after entering PLAY.
- **Note boundaries.**
  - Note k occupies cycles [k*NOTE_CYC, (k+1)*NOTE_CYC) after entry.
  - `busy` falls exactly seqlen*NOTE_CYC cycles after rising.
  - HIT and FIRE return to IDLE; WIN goes to OVER.
- **Preemption** takes effect on the next edge. The new sequence starts at note 0 with fresh counters.
- **Counter widths** are sized by $clog2 of NOTE_CYC and of the largest HALF. There is no overflow at maximum parameter values.

## Configuration
- **`PIEZO_FIRE_SFX_EN` defined:**
  - `fire` edges raise FIRE events;
  - FIRE plays one C6 note;
  - HIT and WIN preempt FIRE.
- **`PIEZO_FIRE_SFX_EN` undefined:**
  - `fire` is ignored and its edge register is removed;
  - only HIT and WIN exist.

## Test plan
All scenarios use CLK_HZ=100000 and NOTE_MS=10. This gives NOTE_CYC=1000 and HALF: C5=95, E5=75, G5=63, C6=47.

- **Plain hit.** Reset, lives 3/3, then `tank1_life` 3→2.
  - `busy` high for exactly 3000 cycles.
  - Toggle intervals are 63 (first 1000 cycles), 75 (next 1000), then 95.
  - Returns to IDLE; `game_over`=0.
- **Win.** `tank2_life` 1→0.
  - 6000-cycle sequence; `piezo_out`=0 throughout cycles 4000–4999.
  - `game_over`=1 from sequence start.
  - A later `tank1_life` drop produces no sound and `busy` stays 0.
- **Preemption.** HIT starts; 500 cycles later `tank2_life` 1→0.
  - Next cycle WIN restarts at note 0 with C5 (interval 95).
  - Total `busy` = 500 + 6000 cycles.
- **Dropped and simultaneous events.**
  - A second HIT during HIT is ignored; `busy` still lasts 3000 cycles.
  - Both tanks decrementing (3→2, 2→1) on the same cycle give one HIT only.
- **Reset behaviour.**
  - Reset during WIN: next cycle `piezo_out`=0, `busy`=0, `game_over`=0.
  - Lives held at 0/2 after reset produce no event.
- **Fire.** With `PIEZO_FIRE_SFX_EN`: `fire` 0→1 gives 1000 cycles of 47-cycle toggles.
  - Without the macro: no output and `busy`=0.

Source files
------------

// File: rtl/piezo_sfx.sv
// Sound-effect sequencer: plays hit/win (and optional fire) jingles on a piezo.
// Define PIEZO_FIRE_SFX_EN to enable the fire blip on rising edges of `fire`.
module piezo_sfx #(
   parameter int unsigned CLK_HZ  = 1000000,
   parameter int unsigned NOTE_MS = 125
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic [1:0] tank1_life,
   input  logic [1:0] tank2_life,
   input  logic       fire,
   output logic       piezo_out,
   output logic       busy,
   output logic       game_over
);

   localparam int unsigned NOTE_CYC = (CLK_HZ / 1000) * NOTE_MS;
   localparam int unsigned HALF_C5  = CLK_HZ / (2 * 523);
   localparam int unsigned HALF_E5  = CLK_HZ / (2 * 659);
   localparam int unsigned HALF_G5  = CLK_HZ / (2 * 784);
   localparam int unsigned HALF_C6  = CLK_HZ / (2 * 1047);
   localparam int unsigned NW = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
   localparam int unsigned HW = (HALF_C5 > 1) ? $clog2(HALF_C5) : 1;
   localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_CYC - 1);

   // Ordered by priority so a plain compare decides preemption.
   typedef enum logic [1:0] {EvNone, EvFire, EvHit, EvWin} ev_e;
   typedef enum logic [1:0] {StIdle, StPlay, StOver} state_e;
   typedef enum logic [2:0] {NoteRest, NoteC5, NoteE5, NoteG5, NoteC6} note_e;

   function automatic note_e seq_note(ev_e s, logic [2:0] i);
      note_e n;
      n = NoteRest;
      case (s)
         EvFire: n = NoteC6;
         EvHit: begin
            case (i)
               3'd0:    n = NoteG5;
               3'd1:    n = NoteE5;
               default: n = NoteC5;
            endcase
         end
         EvWin: begin
            case (i)
               3'd0:    n = NoteC5;
               3'd1:    n = NoteE5;
               3'd2:    n = NoteG5;
               3'd4:    n = NoteRest;
               default: n = NoteC6;
            endcase
         end
         default: n = NoteRest;
      endcase
      return n;
   endfunction

   function automatic logic [2:0] seq_last(ev_e s);
      case (s)
         EvHit:   return 3'd2;
         EvWin:   return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [HW-1:0] half_last(note_e n);
      case (n)
         NoteC5:  return HW'(HALF_C5 - 1);
         NoteE5:  return HW'(HALF_E5 - 1);
         NoteG5:  return HW'(HALF_G5 - 1);
         NoteC6:  return HW'(HALF_C6 - 1);
         default: return '0;
      endcase
   endfunction

   state_e        state_q;
   ev_e           seq_q, ev_q, ev_now;
   logic [2:0]    idx_q;
   logic [NW-1:0] note_cnt_q;
   logic [HW-1:0] half_cnt_q;
   logic [1:0]    p1_q, p2_q;
   logic          primed_q, fire_edge, start;
   note_e         cur_note;

`ifdef PIEZO_FIRE_SFX_EN
   logic fire_q;
   always_ff @(posedge clk) begin
      if (nrst) fire_q <= 1'b0;
      else      fire_q <= fire;
   end
   assign fire_edge = fire & ~fire_q;
`else
   logic unused_fire;
   assign unused_fire = fire;
   assign fire_edge   = 1'b0;
`endif

   // No events on the first cycle after reset: previous lives are not yet valid.
   always_comb begin
      ev_now = EvNone;
      if (primed_q) begin
         if (fire_edge) ev_now = EvFire;
         if ((tank1_life < p1_q && tank1_life != 2'd0) ||
             (tank2_life < p2_q && tank2_life != 2'd0)) ev_now = EvHit;
         if ((tank1_life == 2'd0 && p1_q != 2'd0) ||
             (tank2_life == 2'd0 && p2_q != 2'd0)) ev_now = EvWin;
      end
   end

   assign cur_note = seq_note(seq_q, idx_q);
   assign start    = ((state_q == StIdle) && (ev_q != EvNone)) ||
                     ((state_q == StPlay) && (ev_q > seq_q));

   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q    <= StIdle;
         seq_q      <= EvNone;
         ev_q       <= EvNone;
         idx_q      <= '0;
         note_cnt_q <= '0;
         half_cnt_q <= '0;
         p1_q       <= '0;
         p2_q       <= '0;
         primed_q   <= 1'b0;
         piezo_out  <= 1'b0;
         busy       <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         p1_q     <= tank1_life;
         p2_q     <= tank2_life;
         primed_q <= 1'b1;
         ev_q     <= ev_now;
         if (start) begin
            state_q    <= StPlay;
            seq_q      <= ev_q;
            idx_q      <= '0;
            note_cnt_q <= '0;
            half_cnt_q <= '0;
            piezo_out  <= 1'b0;
            busy       <= 1'b1;
            if (ev_q == EvWin) game_over <= 1'b1;
         end else if (state_q == StPlay) begin
            if (note_cnt_q == NOTE_LAST) begin
               note_cnt_q <= '0;
               half_cnt_q <= '0;
               piezo_out  <= 1'b0;
               if (idx_q == seq_last(seq_q)) begin
                  busy    <= 1'b0;
                  state_q <= (seq_q == EvWin) ? StOver : StIdle;
               end else begin
                  idx_q <= idx_q + 3'd1;
               end
            end else begin
               note_cnt_q <= note_cnt_q + 1'b1;
               if (cur_note == NoteRest) begin
                  piezo_out <= 1'b0;
               end else if (half_cnt_q == half_last(cur_note)) begin
                  piezo_out  <= ~piezo_out;
                  half_cnt_q <= '0;
               end else begin
                  half_cnt_q <= half_cnt_q + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_piezo_sfx.sv
// Self-checking bench for piezo_sfx: vector table, corner sequences and random
// stimulus, all compared every cycle against a note-timeline reference model.
module tb_piezo_sfx;

   localparam int unsigned CLK_HZ  = 100000;
   localparam int unsigned NOTE_MS = 10;
   localparam int NC = 1000;

   logic       clk = 1'b0;
   logic       nrst = 1'b1;
   logic [1:0] tank1_life = 2'd3;
   logic [1:0] tank2_life = 2'd3;
   logic       fire = 1'b0;
   logic       piezo_out, busy, game_over;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   piezo_sfx #(.CLK_HZ(CLK_HZ), .NOTE_MS(NOTE_MS)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .tank1_life (tank1_life),
      .tank2_life (tank2_life),
      .fire       (fire),
      .piezo_out  (piezo_out),
      .busy       (busy),
      .game_over  (game_over)
   );

   // Reference model: mode 0 idle, 1 playing, 2 over; seq 1 fire, 2 hit, 3 win.
   int m_mode = 0, m_seq = 0, m_t = 0, m_go = 0, m_pend = 0;
   int m_p1 = 0, m_p2 = 0, m_pf = 0, m_primed = 0;

   function automatic int seq_len(int s);
      return (s == 3) ? 6 : (s == 2) ? 3 : 1;
   endfunction

   function automatic int note_freq(int s, int k);
      int hit_f [3] = '{784, 659, 523};
      int win_f [6] = '{523, 659, 784, 1047, 0, 1047};
      if (s == 2) return hit_f[k];
      if (s == 3) return win_f[k];
      return 1047;
   endfunction

   function automatic int exp_vec();
      int p, f;
      p = 0;
      if (m_mode == 1) begin
         f = note_freq(m_seq, m_t / NC);
         if (f != 0) p = ((m_t % NC) / (int'(CLK_HZ) / (2 * f))) % 2;
      end
      return p * 4 + ((m_mode == 1) ? 2 : 0) + m_go;
   endfunction

   task automatic model_edge(int r, int l1, int l2, int f);
      int c;
      if (r != 0) begin
         m_mode = 0; m_seq = 0; m_t = 0; m_go = 0; m_pend = 0; m_primed = 0; m_pf = 0;
         return;
      end
      if ((m_mode == 0 && m_pend > 0) || (m_mode == 1 && m_pend > m_seq)) begin
         m_mode = 1; m_seq = m_pend; m_t = 0;
         if (m_pend == 3) m_go = 1;
      end else if (m_mode == 1) begin
         m_t++;
         if (m_t == seq_len(m_seq) * NC) begin
            m_mode = (m_seq == 3) ? 2 : 0;
            m_t = 0;
         end
      end
      c = 0;
      if (m_primed != 0) begin
`ifdef PIEZO_FIRE_SFX_EN
         if (f == 1 && m_pf == 0) c = 1;
`endif
         if ((l1 < m_p1 && l1 != 0) || (l2 < m_p2 && l2 != 0)) c = 2;
         if ((l1 == 0 && m_p1 != 0) || (l2 == 0 && m_p2 != 0)) c = 3;
      end
      m_pend = c; m_p1 = l1; m_p2 = l2; m_pf = f; m_primed = 1;
   endtask

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      int l1, l2, f, r;
      l1 = int'(tank1_life); l2 = int'(tank2_life); f = int'(fire); r = int'(nrst);
      @(posedge clk);
      model_edge(r, l1, l2, f);
      #1;
      check("cycle {piezo,busy,game_over}", int'({piezo_out, busy, game_over}), exp_vec());
   endtask

   task automatic do_reset(input int l1, input int l2);
      nrst = 1'b1;
      tank1_life = 2'(l1);
      tank2_life = 2'(l2);
      fire = 1'b0;
      tick();
      tick();
      nrst = 1'b0;
      repeat (3) tick();
   endtask

   task automatic wait_busy(output int lat);
      lat = 0;
      while (!busy && lat < 4) begin
         tick();
         lat++;
      end
   endtask

   // Counts busy samples from the current one; optionally changes tank2 at sample chg_at.
   task automatic run_busy(input int chg_at, input int chg_val, output int len,
                           output int first);
      len = 0;
      first = -1;
      while (busy && len < 7000) begin
         if (first < 0 && piezo_out) first = len;
         if (len == chg_at) tank2_life = 2'(chg_val);
         tick();
         len++;
      end
   endtask

   typedef struct {
      int a1; int a2; int b1; int b2; int len; int go; int half;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int lat, len, first, cnt;
      vecs[0] = '{3, 3, 2, 3, 3000, 0, 63};
      vecs[1] = '{3, 3, 3, 2, 3000, 0, 63};
      vecs[2] = '{3, 2, 2, 1, 3000, 0, 63};
      vecs[3] = '{1, 3, 0, 3, 6000, 1, 95};
      vecs[4] = '{3, 1, 3, 0, 6000, 1, 95};
      vecs[5] = '{2, 3, 3, 3, 0, 0, 0};
      vecs[6] = '{1, 1, 0, 0, 6000, 1, 95};
      vecs[7] = '{2, 2, 0, 1, 6000, 1, 95};
      vecs[8] = '{3, 3, 1, 3, 3000, 0, 63};

      tick();
      check("reset outputs", int'({piezo_out, busy, game_over}), 0);

      for (int i = 0; i < 9; i++) begin
         do_reset(vecs[i].a1, vecs[i].a2);
         tank1_life = 2'(vecs[i].b1);
         tank2_life = 2'(vecs[i].b2);
         wait_busy(lat);
         if (vecs[i].len == 0) begin
            check($sformatf("vec%0d no event", i), int'(busy), 0);
         end else begin
            check($sformatf("vec%0d latency", i), lat, 2);
            run_busy(-1, 0, len, first);
            check($sformatf("vec%0d busy length", i), len, vecs[i].len);
            check($sformatf("vec%0d first toggle", i), first, vecs[i].half);
            check($sformatf("vec%0d game_over", i), int'(game_over), vecs[i].go);
         end
      end

      // Events in OVER are ignored.
      do_reset(1, 3);
      tank1_life = 2'd0;
      wait_busy(lat);
      run_busy(-1, 0, len, first);
      check("win length", len, 6000);
      tank2_life = 2'd2;
      cnt = 0;
      repeat (100) begin
         tick();
         cnt += int'(busy) + int'(piezo_out);
      end
      check("over ignores hit", cnt, 0);
      check("over game_over", int'(game_over), 1);

      // WIN preempts HIT 500 cycles in.
      do_reset(3, 1);
      tank1_life = 2'd2;
      wait_busy(lat);
      run_busy(498, 0, len, first);
      check("preempt total busy", len, 6500);
      check("preempt game_over", int'(game_over), 1);

      // Second HIT during HIT is dropped.
      do_reset(3, 3);
      tank1_life = 2'd2;
      wait_busy(lat);
      run_busy(1000, 2, len, first);
      check("dropped hit length", len, 3000);

      // Reset mid-WIN, then lives held at 0/2 give no event.
      do_reset(1, 2);
      tank1_life = 2'd0;
      wait_busy(lat);
      repeat (2000) tick();
      nrst = 1'b1;
      tick();
      check("reset piezo", int'(piezo_out), 0);
      check("reset busy", int'(busy), 0);
      check("reset game_over", int'(game_over), 0);
      nrst = 1'b0;
      cnt = 0;
      repeat (20) begin
         tick();
         cnt += int'(busy);
      end
      check("no event after reset", cnt, 0);

      // Fire blip.
      do_reset(3, 3);
      fire = 1'b1;
      wait_busy(lat);
`ifdef PIEZO_FIRE_SFX_EN
      check("fire latency", lat, 2);
      run_busy(-1, 0, len, first);
      check("fire length", len, 1000);
      check("fire first toggle", first, 47);
`else
      cnt = int'(busy);
      repeat (50) begin
         tick();
         cnt += int'(busy) + int'(piezo_out);
      end
      check("fire ignored", cnt, 0);
`endif

      // Random events, checked cycle by cycle against the model.
      do_reset(3, 3);
      for (int i = 0; i < 25; i++) begin
         int gap, r;
         gap = int'($urandom_range(1, 700));
         r = int'($urandom_range(0, 9));
         repeat (gap) tick();
         if (r == 0) begin
            nrst = 1'b1;
            tank1_life = 2'd3;
            tank2_life = 2'd3;
            tick();
            nrst = 1'b0;
         end else if (r <= 2) begin
            fire = ~fire;
         end else if (r <= 6) begin
            if ($urandom_range(0, 1) == 0) begin
               if (tank1_life != 2'd0) tank1_life = tank1_life - 2'd1;
            end else begin
               if (tank2_life != 2'd0) tank2_life = tank2_life - 2'd1;
            end
         end else begin
            tank1_life = 2'($urandom_range(0, 3));
            tank2_life = 2'($urandom_range(0, 3));
         end
      end
      repeat (200) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
